// File: rtl/aes128_rijndael_sbox_lut.sv
// AES Rijndael S-box (forward and inverse) computed arithmetically in GF(2^8),
// with one shared field inverter and an optional output register.
package aes128_type_pkg;
    typedef enum logic {
        ENCRYPT = 1'b0,
        DECRYPT = 1'b1
    } mode_t;
endpackage

module aes128_rijndael_sbox_lut
    import aes128_type_pkg::*;
#(
    parameter bit REGISTERED = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  mode_t      mode_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse for x != 0 and yields 0 for x == 0.
    function automatic logic [7:0] gfInv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gfMul(sq, sq);
            acc = gfMul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] fwdAffine(input logic [7:0] b);
        return b ^ {b[3:0], b[7:4]} ^ {b[4:0], b[7:5]} ^ {b[5:0], b[7:6]}
                 ^ {b[6:0], b[7]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] invAffine(input logic [7:0] x);
        return {x[1:0], x[7:2]} ^ {x[4:0], x[7:5]} ^ {x[6:0], x[7]} ^ 8'h05;
    endfunction

    logic [7:0] inv_in;
    logic [7:0] inv_out;
    logic [7:0] data_d;

    // The inverter sits between the two affine stages, so both directions share it.
    always_comb begin
        inv_in  = (mode_i == DECRYPT) ? invAffine(data_i) : data_i;
        inv_out = gfInv(inv_in);
        data_d  = (mode_i == DECRYPT) ? inv_out : fwdAffine(inv_out);
    end

    if (REGISTERED) begin : g_reg
        logic [7:0] data_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                data_q <= 8'h00;
            end else begin
                data_q <= data_d;
            end
        end

        assign data_o = data_q;
    end else begin : g_comb
        logic unused_ok;
        assign unused_ok = clk_i ^ rst_i;
        assign data_o    = data_d;
    end

endmodule

// File: tb/tb_aes128_rijndael_sbox_lut.sv
// Scoreboard bench for the S-box: a combinational and a registered instance,
// expected bytes queued at stimulus time and checked by a negedge monitor.
module tb_aes128_rijndael_sbox_lut;
    import aes128_type_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    mode_t      combMode;
    mode_t      regMode;
    logic [7:0] combData;
    logic [7:0] regData;
    logic [7:0] combOut;
    logic [7:0] regOut;

    aes128_rijndael_sbox_lut #(.REGISTERED(1'b0)) dutComb (
        .clk_i (clk),
        .rst_i (rst),
        .mode_i(combMode),
        .data_i(combData),
        .data_o(combOut)
    );

    aes128_rijndael_sbox_lut #(.REGISTERED(1'b1)) dutReg (
        .clk_i (clk),
        .rst_i (rst),
        .mode_i(regMode),
        .data_i(regData),
        .data_o(regOut)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    logic [7:0] combQ[$];
    logic [7:0] regQ[$];
    logic       combIssue = 1'b0;
    logic       regIssue  = 1'b0;
    logic       regPend   = 1'b0;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic checkTrue(input string name, input bit ok, input logic [7:0] x, input logic [7:0] y);
        testsRun++;
        if (!ok) begin
            testsFailed++;
            $display("[TB] FAIL %s: x=%02h S(x)=%02h violates property", name, x, y);
        end
    endtask

    task automatic applyStimulus(input bit toReg, input mode_t m, input logic [7:0] d, input logic [7:0] exp);
        @(posedge clk);
        #1;
        if (toReg) begin
            regMode   = m;
            regData   = d;
            regQ.push_back(exp);
            regIssue  = 1'b1;
            combIssue = 1'b0;
        end else begin
            combMode  = m;
            combData  = d;
            combQ.push_back(exp);
            combIssue = 1'b1;
            regIssue  = 1'b0;
        end
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
        combIssue = 1'b0;
        regIssue  = 1'b0;
    endtask

    // Registered results become visible one edge after the inputs were issued.
    always @(posedge clk) begin
        regPend <= regIssue && !rst;
    end

    always @(negedge clk) begin
        if (combIssue) begin
            if (combQ.size() == 0) begin
                checkOutput("comb queue underflow", combOut, 8'hxx);
            end else begin
                checkOutput("comb output", combOut, combQ.pop_front());
            end
        end
        if (regPend) begin
            if (regQ.size() == 0) begin
                checkOutput("reg queue underflow", regOut, 8'hxx);
            end else begin
                checkOutput("reg output", regOut, regQ.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [7:0] encVec[5]  = '{8'h00, 8'h01, 8'h53, 8'h10, 8'hFF};
    logic [7:0] encExp[5]  = '{8'h63, 8'h7C, 8'hED, 8'hCA, 8'h16};
    logic [7:0] decVec[5]  = '{8'h63, 8'hED, 8'h00, 8'h16, 8'h7C};
    logic [7:0] decExp[5]  = '{8'h00, 8'h53, 8'h52, 8'hFF, 8'h01};
    logic [7:0] streamExp[16] = '{8'h63, 8'h7C, 8'h77, 8'h7B, 8'hF2, 8'h6B, 8'h6F, 8'hC5,
                                  8'h30, 8'h01, 8'h67, 8'h2B, 8'hFE, 8'hD7, 8'hAB, 8'h76};
    bit         seen[256];
    logic [7:0] y;
    logic [7:0] xb;

    initial begin
        rst      = 1'b1;
        combMode = ENCRYPT;
        combData = 8'h00;
        regMode  = ENCRYPT;
        regData  = 8'h00;
        #2;
        checkOutput("reg async reset at start", regOut, 8'h00);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, ENCRYPT, encVec[i], encExp[i]);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, DECRYPT, decVec[i], decExp[i]);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, (i % 2 == 0) ? ENCRYPT : DECRYPT, 8'h53,
                          (i % 2 == 0) ? 8'hED : 8'h50);
        end

        for (int x = 0; x < 256; x++) begin
            seen[x] = 1'b0;
        end
        for (int x = 0; x < 256; x++) begin
            xb = 8'(x);
            @(posedge clk);
            #1;
            combIssue = 1'b0;
            combMode  = ENCRYPT;
            combData  = xb;
            #1;
            y = combOut;
            checkTrue("no fixed point", y !== xb, xb, y);
            checkTrue("no opposite fixed point", y !== (xb ^ 8'hFF), xb, y);
            checkTrue("permutation", (^y !== 1'bx) && !seen[y], xb, y);
            if (^y !== 1'bx) begin
                seen[y] = 1'b1;
            end
            combMode  = DECRYPT;
            combData  = y;
            combQ.push_back(xb);
            combIssue = 1'b1;
        end
        idleCycle();

        @(negedge clk);
        checkOutput("reg held in reset", regOut, 8'h00);

        @(posedge clk);
        #1;
        rst      = 1'b0;
        regMode  = ENCRYPT;
        regData  = 8'h53;
        regQ.push_back(8'hED);
        regIssue = 1'b1;
        #1;
        checkOutput("reg before first edge", regOut, 8'h00);

        applyStimulus(1'b1, DECRYPT, 8'h53, 8'h50);
        applyStimulus(1'b1, ENCRYPT, 8'h53, 8'hED);
        applyStimulus(1'b1, DECRYPT, 8'h53, 8'h50);

        for (int b = 0; b < 8; b++) begin
            applyStimulus(1'b1, ENCRYPT, 8'(b), streamExp[b]);
        end
        @(posedge clk);
        #1;
        regMode  = ENCRYPT;
        regData  = 8'h08;
        regIssue = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("reg async reset mid-stream", regOut, 8'h00);
        @(negedge clk);
        checkOutput("reg pending byte dropped", regOut, 8'h00);

        for (int b = 9; b < 16; b++) begin
            applyStimulus(1'b1, ENCRYPT, 8'(b), streamExp[b]);
            rst = 1'b0;
        end
        idleCycle();
        idleCycle();

        testsRun++;
        if ((combQ.size() != 0) || (regQ.size() != 0)) begin
            testsFailed++;
            $display("[TB] FAIL queues drained: comb=%0d reg=%0d left, expected 0", combQ.size(), regQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/aes128_rijndael_sbox_lut.md
Name: aes128_rijndael_sbox_lut

Overview:
Single-byte AES Rijndael substitution box with forward (SubBytes) and inverse (InvSubBytes) modes. It is the S-box primitive used by the AES-128 SubBytes stage, which feeds one byte per cycle and consumes the result in the same cycle. An optional output register is available for timing-constrained builds.

Parameters:
REGISTERED, 0, 0 = data_o is purely combinational from mode_i/data_i (zero latency); 1 = data_o is registered (1-cycle latency).

Ports:
clk_i  input  1  clock; used only when REGISTERED=1.
rst_i  input  1  asynchronous active-high reset; used only when REGISTERED=1.
mode_i  input  mode_t (1 bit, from aes128_type_pkg)  ENCRYPT (0) selects forward S-box; DECRYPT (1) selects inverse S-box.
data_i  input  8  byte to substitute.
data_o  output  8  substituted byte.

Interface decision (already decided): one clock; reset is asynchronous and active-high. Ports are named clk_i and rst_i.

Behaviour:
- Forward: data_o = S(data_i).
  - Step 1: b = multiplicative inverse of data_i in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11B), with inverse(0x00) = 0x00.
  - Step 2: apply the Rijndael affine transform: out[i] = b[i]^b[(i+4)%8]^b[(i+5)%8]^b[(i+6)%8]^b[(i+7)%8]^c[i], with c = 0x63.
- Inverse: data_o = InvS(data_i).
  - Step 1: inverse affine: a[i] = x[(i+2)%8]^x[(i+5)%8]^x[(i+7)%8]^d[i], with d = 0x05.
  - Step 2: GF(2^8) inverse of a, with 0 mapping to 0.
- Bit-exact with FIPS-197 tables. InvS(S(x)) = x for all 256 x.
- Implementation style is free: two 256-entry case tables, or a composite-field GF((2^4)^2) datapath with shared inversion. It must be synthesizable and latch-free.
- REGISTERED=0:
  - Pure combinational logic; data_o settles in the same cycle as mode_i/data_i change.
  - clk_i and rst_i are ignored; no state exists.
- REGISTERED=1:
  - data_o <= f(mode_i, data_i) on every rising edge of clk_i, with no enable. Result appears 1 cycle after the inputs.
  - Reset: rst_i=1 asynchronously forces data_o = 0x00 immediately, independent of the clock.
  - While rst_i is held high, data_o stays 0x00.
  - First valid output is at the first rising edge after rst_i deasserts, reflecting the inputs sampled at that edge.
  - Reset asserted mid-stream discards the in-flight result.
- Mode may change every cycle. The output always reflects the mode paired with the data in the same cycle (or in the same sampling edge when REGISTERED=1).
- Boundary values: S(0x00)=0x63, S(0xFF)=0x16, InvS(0x00)=0x52, InvS(0xFF)=0x7D.
- No X propagation from defined inputs. Every one of the 2x256 input combinations yields a defined byte.

Test Plan:
- REGISTERED=0, ENCRYPT:
  - data_i=0x00 -> 0x63; 0x01 -> 0x7C; 0x53 -> 0xED; 0x10 -> 0xCA; 0xFF -> 0x16.
- REGISTERED=0, DECRYPT:
  - data_i=0x63 -> 0x00; 0xED -> 0x53; 0x00 -> 0x52; 0x16 -> 0xFF; 0x7C -> 0x01.
- Exhaustive round trip:
  - For all x in 0..255, feed S(x) in DECRYPT -> x.
  - The 256 forward outputs form a permutation with no fixed points (S(x) != x) and no opposite fixed points (S(x) != x^0xFF).
- Alternating mode each cycle with data_i=0x53 -> ENCRYPT 0xED, DECRYPT 0x50, with no cross-mode contamination.
- REGISTERED=1:
  - Assert rst_i between clock edges -> data_o=0x00 immediately.
  - Release rst_i, drive ENCRYPT 0x53 -> data_o=0xED after the next rising edge. Still 0x00 before that edge.
- REGISTERED=1, stream 16 bytes 0x00..0x0F in ENCRYPT:
  - Outputs lag by one cycle: 63,7C,77,7B,F2,6B,6F,C5,30,01,67,2B,FE,D7,AB,76.
  - Asserting rst_i at byte 8 forces 0x00 and drops the pending 0x30.
